// File: rtl/mips_chk_pkg.sv
// Shared types for the MIPS store checker: FSM states and verdict codes.
package mips_chk_pkg;

  typedef enum logic [2:0] {
    CHK_IDLE    = 3'd0,
    CHK_RUN     = 3'd1,
    CHK_PASS    = 3'd2,
    CHK_FAIL    = 3'd3,
    CHK_TIMEOUT = 3'd4
  } chk_state_e;

  localparam logic [1:0] VERDICT_NONE    = 2'd0;
  localparam logic [1:0] VERDICT_PASS    = 2'd1;
  localparam logic [1:0] VERDICT_FAIL    = 2'd2;
  localparam logic [1:0] VERDICT_TIMEOUT = 2'd3;

  // Terminal state reached for a given verdict code.
  function automatic chk_state_e verdict_state(input logic [1:0] verdict);
    case (verdict)
      VERDICT_PASS:    return CHK_PASS;
      VERDICT_FAIL:    return CHK_FAIL;
      VERDICT_TIMEOUT: return CHK_TIMEOUT;
      default:         return CHK_RUN;
    endcase
  endfunction

endpackage

// File: rtl/chk_expect_table.sv
// Expected-store table: one synchronous write port, two combinational reads
// (the entry being matched next and the last valid entry).
module chk_expect_table
  import mips_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WIDTH-1:0]         wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_dc,
  input  logic [$clog2(DEPTH)-1:0] cur_idx,
  output logic [WIDTH-1:0]         cur_addr_c,
  output logic [WIDTH-1:0]         cur_data_c,
  output logic                     cur_dc_c,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  output logic [WIDTH-1:0]         last_addr_c
);

  localparam int unsigned ENT_W = 2 * WIDTH + 1;

  // Entry layout: {dc, addr, data}. Contents survive reset on purpose.
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = {wr_dc, wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cur_dc_c    = mem_q[cur_idx][ENT_W-1];
  assign cur_addr_c  = mem_q[cur_idx][2*WIDTH-1:WIDTH];
  assign cur_data_c  = mem_q[cur_idx][WIDTH-1:0];
  assign last_addr_c = mem_q[last_idx][2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mips_write_checker.sv
// Snoops the core's data-memory store port and checks every store against a
// loadable table of expected writes, reporting pass/fail/timeout in hardware.
module mips_write_checker
  import mips_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CYCLE_LIMIT = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [WIDTH-1:0]         dataadr,
  input  logic [WIDTH-1:0]         writedata,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_idx,
  input  logic [WIDTH-1:0]         exp_addr,
  input  logic [WIDTH-1:0]         exp_data,
  input  logic                     exp_dc,
  input  logic [$clog2(DEPTH):0]   exp_count,
  input  logic                     strict,
  input  logic                     start,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   match_idx,
  output logic [CNT_W-1:0]         write_cnt,
  output logic [CNT_W-1:0]         ignored_cnt,
  output logic [CNT_W-1:0]         cycles,
  output logic [WIDTH-1:0]         fail_addr,
  output logic [WIDTH-1:0]         fail_data
);

  localparam int unsigned      IDX_W      = $clog2(DEPTH);
  localparam int unsigned      MI_W       = IDX_W + 1;
  localparam logic [MI_W-1:0]  DEPTH_M    = MI_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(CYCLE_LIMIT - 1);

  chk_state_e       state_q, state_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [MI_W-1:0]  match_idx_q, match_idx_d;
  logic [MI_W-1:0]  exp_count_q, exp_count_d;
  logic             strict_q, strict_d;
  logic [CNT_W-1:0] write_cnt_q, write_cnt_d;
  logic [CNT_W-1:0] ignored_cnt_q, ignored_cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0] fail_data_q, fail_data_d;

  logic [WIDTH-1:0] cur_addr_c;
  logic [WIDTH-1:0] cur_data_c;
  logic             cur_dc_c;
  logic [WIDTH-1:0] last_addr_c;
  logic             table_we_c;
  logic [IDX_W-1:0] last_idx_c;

  logic             store_hit;
  logic [MI_W-1:0]  mi_inc;
  logic [MI_W-1:0]  count_clamped;
  logic [1:0]       verdict;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign table_we_c = exp_we && (state_q == CHK_IDLE);
  assign last_idx_c = IDX_W'(exp_count_q - MI_W'(1));

  chk_expect_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk         (clk),
    .wr_en       (table_we_c),
    .wr_idx      (exp_idx),
    .wr_addr     (exp_addr),
    .wr_data     (exp_data),
    .wr_dc       (exp_dc),
    .cur_idx     (match_idx_q[IDX_W-1:0]),
    .cur_addr_c  (cur_addr_c),
    .cur_data_c  (cur_data_c),
    .cur_dc_c    (cur_dc_c),
    .last_idx    (last_idx_c),
    .last_addr_c (last_addr_c)
  );

  // Next-state, counters and verdict flags.
  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    match_idx_d   = match_idx_q;
    exp_count_d   = exp_count_q;
    strict_d      = strict_q;
    write_cnt_d   = write_cnt_q;
    ignored_cnt_d = ignored_cnt_q;
    cycles_d      = cycles_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
    verdict       = VERDICT_NONE;
    store_hit     = (dataadr == cur_addr_c) && (cur_dc_c || (writedata == cur_data_c));
    mi_inc        = match_idx_q + MI_W'(1);
    count_clamped = (exp_count > DEPTH_M) ? DEPTH_M : exp_count;

    unique case (state_q)
      CHK_IDLE: begin
        if (start) begin
          exp_count_d   = count_clamped;
          strict_d      = strict;
          match_idx_d   = '0;
          write_cnt_d   = '0;
          ignored_cnt_d = '0;
          cycles_d      = '0;
          fail_addr_d   = '0;
          fail_data_d   = '0;
          if (count_clamped == '0) begin
            verdict = VERDICT_PASS;
          end else begin
            state_d = CHK_RUN;
          end
        end
      end
      CHK_RUN: begin
        cycles_d = sat_inc(cycles_q);
        if (memwrite) begin
          write_cnt_d = sat_inc(write_cnt_q);
          if (store_hit) begin
            match_idx_d = mi_inc;
            if (mi_inc == exp_count_q) begin
              verdict = VERDICT_PASS;
            end
          end else if (strict_q || (dataadr == last_addr_c)) begin
            // A stray store to the final expected address can never be recovered.
            verdict     = VERDICT_FAIL;
            fail_addr_d = dataadr;
            fail_data_d = writedata;
          end else begin
            ignored_cnt_d = sat_inc(ignored_cnt_q);
          end
        end
        if ((verdict == VERDICT_NONE) && (cycles_q == LAST_CYCLE)) begin
          verdict = VERDICT_TIMEOUT;
        end
      end
      default: begin
      end
    endcase

    if (verdict != VERDICT_NONE) begin
      state_d   = verdict_state(verdict);
      done_d    = 1'b1;
      pass_d    = (verdict == VERDICT_PASS);
      fail_d    = (verdict == VERDICT_FAIL);
      timeout_d = (verdict == VERDICT_TIMEOUT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CHK_IDLE;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      match_idx_q   <= '0;
      exp_count_q   <= '0;
      strict_q      <= 1'b0;
      write_cnt_q   <= '0;
      ignored_cnt_q <= '0;
      cycles_q      <= '0;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
      match_idx_q   <= match_idx_d;
      exp_count_q   <= exp_count_d;
      strict_q      <= strict_d;
      write_cnt_q   <= write_cnt_d;
      ignored_cnt_q <= ignored_cnt_d;
      cycles_q      <= cycles_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign match_idx   = match_idx_q;
  assign write_cnt   = write_cnt_q;
  assign ignored_cnt = ignored_cnt_q;
  assign cycles      = cycles_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mips_write_checker.sv
// Self-checking bench for mips_write_checker: directed scenarios plus random
// store streams scored against a store-list reference model.
module tb_mips_write_checker;

  localparam int unsigned W    = 32;
  localparam int unsigned D    = 8;
  localparam int unsigned LIM  = 20;
  localparam int unsigned CW   = 16;
  localparam int          MAXC = LIM + 4;

  logic          clk;
  logic          reset, memwrite, exp_we, exp_dc, strict, start;
  logic [W-1:0]  dataadr, writedata, exp_addr, exp_data;
  logic [2:0]    exp_idx;
  logic [3:0]    exp_count;
  logic          done, pass, fail, timeout;
  logic [3:0]    match_idx;
  logic [CW-1:0] write_cnt, ignored_cnt, cycles;
  logic [W-1:0]  fail_addr, fail_data;

  mips_write_checker #(
    .WIDTH       (W),
    .DEPTH       (D),
    .CYCLE_LIMIT (LIM),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .exp_we      (exp_we),
    .exp_idx     (exp_idx),
    .exp_addr    (exp_addr),
    .exp_data    (exp_data),
    .exp_dc      (exp_dc),
    .exp_count   (exp_count),
    .strict      (strict),
    .start       (start),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .match_idx   (match_idx),
    .write_cnt   (write_cnt),
    .ignored_cnt (ignored_cnt),
    .cycles      (cycles),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected table and per-RUN-cycle store stimulus (index k = k-th RUN edge).
  logic [W-1:0] t_addr [D];
  logic [W-1:0] t_data [D];
  bit           t_dc   [D];
  bit           s_we   [MAXC+1];
  logic [W-1:0] s_addr [MAXC+1];
  logic [W-1:0] s_data [MAXC+1];

  int n_cmp, n_bad;

  // Reference results: verdict 1=pass 2=fail 3=timeout, m_k = RUN edge of verdict.
  int           m_verdict, m_k, m_mi, m_wc, m_ig, m_cyc;
  logic [W-1:0] m_fa, m_fd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Walk the store list the way the checker's rules describe it.
  task automatic model(input int cnt_in, input bit strict_in);
    int cnt;
    cnt = (cnt_in > int'(D)) ? int'(D) : cnt_in;
    m_verdict = 0; m_k = 0; m_mi = 0; m_wc = 0; m_ig = 0; m_cyc = 0;
    m_fa = '0; m_fd = '0;
    if (cnt == 0) begin
      m_verdict = 1;
      return;
    end
    for (int k = 1; k <= int'(LIM); k++) begin
      m_cyc = k;
      if (s_we[k]) begin
        m_wc++;
        if (s_addr[k] == t_addr[m_mi] && (t_dc[m_mi] || s_data[k] == t_data[m_mi])) begin
          m_mi++;
          if (m_mi == cnt) begin
            m_verdict = 1; m_k = k;
            return;
          end
        end else if (strict_in || s_addr[k] == t_addr[cnt-1]) begin
          m_verdict = 2; m_k = k; m_fa = s_addr[k]; m_fd = s_data[k];
          return;
        end else begin
          m_ig++;
        end
      end
    end
    m_verdict = 3; m_k = int'(LIM);
  endtask

  task automatic check_zero(input string name);
    check_eq({name, "/rst_done"},    64'(done), 64'(0));
    check_eq({name, "/rst_pass"},    64'(pass), 64'(0));
    check_eq({name, "/rst_fail"},    64'(fail), 64'(0));
    check_eq({name, "/rst_timeout"}, 64'(timeout), 64'(0));
    check_eq({name, "/rst_midx"},    64'(match_idx), 64'(0));
    check_eq({name, "/rst_wcnt"},    64'(write_cnt), 64'(0));
    check_eq({name, "/rst_icnt"},    64'(ignored_cnt), 64'(0));
    check_eq({name, "/rst_cycles"},  64'(cycles), 64'(0));
    check_eq({name, "/rst_faddr"},   64'(fail_addr), 64'(0));
    check_eq({name, "/rst_fdata"},   64'(fail_data), 64'(0));
  endtask

  task automatic clr_stim();
    for (int k = 0; k <= MAXC; k++) begin
      s_we[k] = 1'b0; s_addr[k] = '0; s_data[k] = '0;
    end
  endtask

  task automatic put(input int k, input int a, input int d);
    s_we[k] = 1'b1; s_addr[k] = W'(a); s_data[k] = W'(d);
  endtask

  task automatic set_tab2();
    for (int i = 0; i < int'(D); i++) begin
      t_addr[i] = W'(200 + 4 * i); t_data[i] = W'(i); t_dc[i] = 1'b0;
    end
    t_addr[0] = 80; t_data[0] = 7;
    t_addr[1] = 84; t_data[1] = 7;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; memwrite = 1'b0; start = 1'b0; exp_we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Reset, optionally load the table, start and replay the store list.
  task automatic run(input string name, input int cnt, input bit strict_in,
                     input bit load, input bit we_noise);
    pulse_reset();
    check_zero(name);
    if (load) begin
      for (int i = 0; i < int'(D); i++) begin
        exp_we = 1'b1; exp_idx = 3'(i);
        exp_addr = t_addr[i]; exp_data = t_data[i]; exp_dc = t_dc[i];
        @(posedge clk); #1;
      end
      exp_we = 1'b0;
    end
    model(cnt, strict_in);
    exp_count = 4'(cnt); strict = strict_in; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({name, "/done_at_start"}, 64'(done), 64'(m_k == 0));
    for (int k = 1; k <= MAXC - 1; k++) begin
      memwrite = s_we[k]; dataadr = s_addr[k]; writedata = s_data[k];
      if (we_noise) begin
        exp_we = 1'b1; exp_idx = 3'($urandom_range(0, 7));
        exp_addr = $urandom; exp_data = $urandom; exp_dc = 1'b1;
      end
      @(posedge clk); #1;
      check_eq($sformatf("%s/done_c%0d", name, k), 64'(done), 64'(k >= m_k));
    end
    memwrite = 1'b0; exp_we = 1'b0;
    check_eq({name, "/pass"},    64'(pass), 64'(m_verdict == 1));
    check_eq({name, "/fail"},    64'(fail), 64'(m_verdict == 2));
    check_eq({name, "/timeout"}, 64'(timeout), 64'(m_verdict == 3));
    check_eq({name, "/midx"},    64'(match_idx), 64'(m_mi));
    check_eq({name, "/wcnt"},    64'(write_cnt), 64'(m_wc));
    check_eq({name, "/icnt"},    64'(ignored_cnt), 64'(m_ig));
    check_eq({name, "/cycles"},  64'(cycles), 64'(m_cyc));
    check_eq({name, "/faddr"},   64'(fail_addr), 64'(m_fa));
    check_eq({name, "/fdata"},   64'(fail_data), 64'(m_fd));
  endtask

  initial begin
    int mi, cnt;
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
    exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0; exp_dc = 1'b0;
    exp_count = '0; strict = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // Strict, in-order stores.
    set_tab2(); clr_stim(); put(1, 80, 7); put(2, 84, 7);
    run("strict_pass", 2, 1'b1, 1'b1, 1'b0);

    // Reset after one matched store, then re-run on the retained table.
    pulse_reset();
    exp_count = 4'd2; strict = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; memwrite = 1'b1; dataadr = 80; writedata = 7;
    @(posedge clk); #1;
    memwrite = 1'b0;
    check_eq("midrst/midx_before", 64'(match_idx), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero("midrst");
    run("rerun_no_load", 2, 1'b1, 1'b0, 1'b0);

    // Table writes outside IDLE must not land.
    run("we_in_run", 2, 1'b1, 1'b0, 1'b1);
    run("after_we_noise", 2, 1'b1, 1'b0, 1'b0);

    clr_stim(); put(1, 60, 3); put(2, 80, 7); put(3, 84, 7);
    run("nonstrict_skip", 2, 1'b0, 1'b1, 1'b0);
    run("strict_stray", 2, 1'b1, 1'b0, 1'b0);

    clr_stim(); put(1, 80, 7); put(2, 84, 9);
    run("last_addr_bad", 2, 1'b0, 1'b0, 1'b0);
    t_dc[1] = 1'b1;
    run("last_dc", 2, 1'b0, 1'b1, 1'b0);
    t_dc[1] = 1'b0;

    clr_stim();
    run("timeout", 2, 1'b1, 1'b1, 1'b0);
    put(5, 80, 7); put(int'(LIM), 84, 7);
    run("pass_on_limit", 2, 1'b1, 1'b0, 1'b0);

    clr_stim();
    run("count_zero", 0, 1'b1, 1'b0, 1'b0);

    // exp_count above DEPTH is clamped to the full table.
    for (int i = 0; i < int'(D); i++) begin
      t_addr[i] = W'(100 + 4 * i); t_data[i] = W'(i + 1); t_dc[i] = 1'b0;
      put(i + 1, 100 + 4 * i, i + 1);
    end
    run("clamp", 12, 1'b1, 1'b1, 1'b0);

    // Random tables and store streams over a small address/data space.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < int'(D); i++) begin
        t_addr[i] = W'(4 * $urandom_range(0, 7));
        t_data[i] = W'($urandom_range(0, 3));
        t_dc[i]   = ($urandom_range(0, 3) == 0);
      end
      cnt = int'($urandom_range(0, 10));
      clr_stim();
      mi = 0;
      for (int k = 1; k <= int'(LIM); k++) begin
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 3) != 0 && mi < int'(D)) begin
            put(k, int'(t_addr[mi]), t_dc[mi] ? int'($urandom_range(0, 3)) : int'(t_data[mi]));
            mi++;
          end else begin
            put(k, int'(4 * $urandom_range(0, 7)), int'($urandom_range(0, 3)));
          end
        end
      end
      run($sformatf("rand%0d", r), cnt, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_write_checker.md
# mips_write_checker

Synthesizable, parametrised self-checker that sits beside the `top` MIPS core, either in simulation or on an FPGA. It snoops the data-memory write port (`memwrite`, `dataadr`, `writedata`) and compares every store against a loadable table of expected (address, data) writes. It reports pass, fail or timeout in hardware, replacing testbench-only checking that hard-codes a single address/data pair.

## Interface
- `WIDTH`, 32: address/data width.
- `DEPTH`, 8: expected-write table entries (power of 2, ≥2).
- `CYCLE_LIMIT`, 1000: RUN cycles before timeout (≥1).
- `CNT_W`, 16: width of cycle and write counters; must hold CYCLE_LIMIT.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `memwrite`  in  1  core store strobe.
- `dataadr`  in  WIDTH  store byte address.
- `writedata`  in  WIDTH  store data.
- `exp_we`  in  1  table write enable (IDLE only).
- `exp_idx`  in  log2(DEPTH)  table entry index.
- `exp_addr`  in  WIDTH  expected address.
- `exp_data`  in  WIDTH  expected data.
- `exp_dc`  in  1  data don't-care for this entry.
- `exp_count`  in  log2(DEPTH)+1  number of valid entries, sampled at `start`.
- `strict`  in  1  mode, sampled at `start`: 1 = every store must match next entry.
- `start`  in  1  one-cycle pulse, IDLE→RUN.
- `done`  out  1  verdict reached (PASS/FAIL/TIMEOUT).
- `pass`, `fail`, `timeout`  out  1 each  one-hot verdict, all 0 before done.
- `match_idx`  out  log2(DEPTH)+1  entries matched so far.
- `write_cnt`  out  CNT_W  stores seen in RUN.
- `ignored_cnt`  out  CNT_W  non-matching stores skipped (non-strict).
- `cycles`  out  CNT_W  RUN cycles elapsed.
- `fail_addr`, `fail_data`  out  WIDTH  store that caused FAIL.

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. PASS/FAIL/TIMEOUT are sticky until `reset`.
- IDLE: `exp_we` writes entry `exp_idx`. `start` latches `exp_count`/`strict`, clears counters, →RUN. `start` with `exp_count`=0 →PASS directly. `exp_we` outside IDLE is ignored. `exp_count`>DEPTH is clamped to DEPTH.
- RUN: `cycles` increments every cycle. On `memwrite`, increment `write_cnt` and compare with entry[`match_idx`].
- A store matches when address is equal and (data is equal or `exp_dc`=1). On a match, `match_idx`+1. If the new value equals `exp_count`, →PASS.
- Mismatch, strict: →FAIL and capture `fail_addr`/`fail_data`.
- Mismatch, non-strict: if `dataadr` equals the address of the last valid entry, →FAIL with capture. Otherwise `ignored_cnt`+1 and stay in RUN.
- Timeout: when `cycles` = CYCLE_LIMIT−1 and no verdict this cycle, →TIMEOUT.
- Simultaneous events: a store verdict in the same cycle as the limit takes precedence; PASS or FAIL wins over TIMEOUT.
- `start` while in RUN or a verdict state is ignored.
- `memwrite` in IDLE or a verdict state is not counted.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset value of all outputs is 0. State is IDLE. Table contents are not reset.
- Inputs are sampled on the rising edge. Outputs are registered and reflect the edge on which the decisive store was sampled, i.e. one cycle of latency after the store.
- `start` at edge N: `cycles`=1 after edge N+1.
- Back-to-back stores, one per cycle, are all checked; there is no stall.
- `reset` mid-RUN: returns to IDLE on that edge and clears all outputs. The table is retained, so `start` can be re-issued immediately.

## Structure
- Package `mips_chk_pkg`: state enum (`CHK_IDLE`, `CHK_RUN`, `CHK_PASS`, `CHK_FAIL`, `CHK_TIMEOUT`) and a verdict-code localparam.
- Sub-module `chk_expect_table`: DEPTH×(2·WIDTH+1) register array with synchronous write port and combinational read at `match_idx` and at `exp_count`−1.
- The FSM, counters and comparators live in `mips_write_checker`.

## Test plan
- Load {(80,7),(84,7)}, strict, `start`, then drive stores (80,7),(84,7) → `pass`=1 one cycle after the second store, `match_idx`=2, `write_cnt`=2.
- Same table, non-strict, stores (60,3),(80,7),(84,7) → `pass`=1, `ignored_cnt`=1. In strict mode the same sequence → `fail`=1, `fail_addr`=60, `fail_data`=3.
- Non-strict, stores (80,7),(84,9) → `fail`=1, `fail_addr`=84, `fail_data`=9. With entry 1 `exp_dc`=1 → `pass`=1.
- CYCLE_LIMIT=20, no stores → `timeout`=1 after exactly 20 RUN cycles, `cycles`=20. A final matching store on cycle 20 → `pass`, not `timeout`.
- `reset` asserted after one matched store → all outputs 0, IDLE. Re-`start` plus the full sequence → `pass` without reloading the table.
- `exp_count`=0 with `start` → `pass` on the next cycle. `exp_we` during RUN leaves the table unchanged (checked by a subsequent pass).
